// File: rtl/sar_sched_pkg.sv
// Shared types and sizing helpers for the SAR conversion scheduler.
package sar_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SETTLE,
    CONVERT,
    OUTPUT
  } sched_state_e;

  // Channel-index width; never below one bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // CONVERT cycles allowed before the watchdog gives up on eoc.
  function automatic int wd_limit(input int n_bits);
    return 2 * n_bits + 2;
  endfunction

endpackage

// File: rtl/sar_rr_arbiter.sv
// Combinational round-robin pick: first pending channel at or after ptr.
module sar_rr_arbiter
  import sar_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = chan_w(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] grant_idx,
  output logic          grant_vld
);

  // Walk offsets from farthest to nearest so the nearest pending one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (pending[idx]) begin
        grant     = N'(1) << idx;
        grant_idx = CW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_conversion_scheduler.sv
// Round-robin scheduler for the shared SAR ADC datapath (mux, S/H, SAR).
// Optional eoc watchdog enabled by defining SAR_SCHED_WATCHDOG_EN.
module sar_conversion_scheduler
  import sar_sched_pkg::*;
#(
  parameter int N_BITS        = 10,
  parameter int N_CHANNELS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_CHANNELS-1:0]          chan_req,
  output logic [chan_w(N_CHANNELS)-1:0]  mux_sel,
  output logic                           sample_en,
  output logic                           conduct_comparison,
  output logic                           sar_clear,
  input  logic                           eoc,
  input  logic [N_BITS-1:0]              quantized_voltage,
  input  logic                           feedback_value,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [N_BITS-1:0]              result_data,
  output logic [chan_w(N_CHANNELS)-1:0]  result_channel,
  output logic                           busy,
  output logic                           error
);

  localparam int CW = chan_w(N_CHANNELS);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  sched_state_e          state, state_n;
  logic [N_CHANNELS-1:0] pending;
  logic [CW-1:0]         ptr, chan_q;
  logic [SW-1:0]         settle_cnt;
  logic [N_BITS-1:0]     result_q;
  logic                  sar_clear_q;
  logic                  wd_fire;
  logic                  any_req;

  logic [N_CHANNELS-1:0] grant;
  logic [CW-1:0]         grant_idx;
  logic                  grant_vld;

  sar_rr_arbiter #(.N(N_CHANNELS), .CW(CW)) u_arb (
    .pending   (pending),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // The SAR has not yet registered its LSB at eoc; the comparator supplies it.
  logic unused_sar_lsb;
  assign unused_sar_lsb = quantized_voltage[0];

  assign any_req = |(pending | chan_req);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ARB;
      ARB:     state_n = grant_vld ? SETTLE : IDLE;
      SETTLE:  if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_n = CONVERT;
      CONVERT: begin
        if (eoc)          state_n = OUTPUT;
        else if (wd_fire) state_n = any_req ? ARB : IDLE;
      end
      OUTPUT:  if (result_ready) state_n = any_req ? ARB : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pending     <= '0;
      ptr         <= '0;
      chan_q      <= '0;
      settle_cnt  <= '0;
      result_q    <= '0;
      sar_clear_q <= 1'b1;
    end else begin
      state       <= state_n;
      sar_clear_q <= 1'b0;
      // A request arriving in the granting cycle re-sets the bit.
      pending     <= (pending & ~((state == ARB) ? grant : '0)) | chan_req;
      settle_cnt  <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;
      if (state == ARB && grant_vld) begin
        chan_q <= grant_idx;
        ptr    <= (grant_idx == CW'(N_CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
      end
      if (state == CONVERT && eoc)
        result_q <= {quantized_voltage[N_BITS-1:1], feedback_value};
    end
  end

`ifdef SAR_SCHED_WATCHDOG_EN
  localparam int WD_LIM = wd_limit(N_BITS);
  localparam int WDW    = $clog2(WD_LIM + 1);

  logic [WDW-1:0] wd_cnt;
  logic           error_q;

  // Fires in the last allowed CONVERT cycle; eoc in that same cycle still wins.
  assign wd_fire = (state == CONVERT) && !eoc && (wd_cnt == WDW'(WD_LIM - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      wd_cnt <= (state == CONVERT) ? wd_cnt + WDW'(1) : '0;
      if (wd_fire) error_q <= 1'b1;
    end
  end

  assign error = error_q | wd_fire;
`else
  assign wd_fire = 1'b0;
  assign error   = 1'b0;
`endif

  assign mux_sel            = chan_q;
  assign result_channel     = chan_q;
  assign result_data        = result_q;
  assign sample_en          = (state == SETTLE);
  assign conduct_comparison = (state == CONVERT) && !wd_fire;
  assign result_valid       = (state == OUTPUT);
  assign busy               = (state != IDLE);
  assign sar_clear          = sar_clear_q | wd_fire;

endmodule

// File: tb/tb_sar_conversion_scheduler.sv
// Directed bench for sar_conversion_scheduler: vector table plus corner sequences.
module tb_sar_conversion_scheduler;

  localparam int NB  = 10;
  localparam int NC  = 4;
  localparam int S   = 4;
  localparam int LAT = 2 + S + 2 * NB;   // request cycle to result_valid

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] chan_req;
  logic [1:0]    mux_sel;
  logic          sample_en, conduct_comparison, sar_clear;
  logic          eoc;
  logic [NB-1:0] quantized_voltage;
  logic          feedback_value;
  logic          result_valid, result_ready;
  logic [NB-1:0] result_data;
  logic [1:0]    result_channel;
  logic          busy, error;
  logic          eoc_en;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sar_conversion_scheduler #(.N_BITS(NB), .N_CHANNELS(NC), .SETTLE_CYCLES(S)) dut (
    .clk                (clk),
    .reset              (reset),
    .chan_req           (chan_req),
    .mux_sel            (mux_sel),
    .sample_en          (sample_en),
    .conduct_comparison (conduct_comparison),
    .sar_clear          (sar_clear),
    .eoc                (eoc),
    .quantized_voltage  (quantized_voltage),
    .feedback_value     (feedback_value),
    .result_valid       (result_valid),
    .result_ready       (result_ready),
    .result_data        (result_data),
    .result_channel     (result_channel),
    .busy               (busy),
    .error              (error)
  );

  // SAR model: eoc in the 2*NB-th cycle of conduct_comparison.
  int mc;
  always @(posedge clk or negedge reset) begin
    if (!reset)                  mc <= 0;
    else if (conduct_comparison) mc <= mc + 1;
    else                         mc <= 0;
  end
  assign eoc = eoc_en && (mc == 2 * NB - 1);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (result_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse(input logic [NC-1:0] r);
    chan_req = r;
    tick();
    chan_req = '0;
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    chan_req     = '0;
    result_ready = 1'b0;
    eoc_en       = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [NC-1:0] req;
    logic [NB-1:0] qv;
    logic          fb;
    logic [1:0]    ch;
    logic [NB-1:0] data;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n, extra;
    logic ok;

    tbl[0] = '{4'b0100, 10'h2A4, 1'b1, 2'd2, 10'h2A5};
    tbl[1] = '{4'b0001, 10'h3FF, 1'b0, 2'd0, 10'h3FE};
    tbl[2] = '{4'b0010, 10'h000, 1'b1, 2'd1, 10'h001};
    tbl[3] = '{4'b1000, 10'h155, 1'b0, 2'd3, 10'h154};
    tbl[4] = '{4'b0100, 10'h2AA, 1'b1, 2'd2, 10'h2AB};

    reset = 1'b0; chan_req = '0; result_ready = 1'b0; eoc_en = 1'b1;
    quantized_voltage = '0; feedback_value = 1'b0;
    #12;
    chk("rst_sar_clear", 32'(sar_clear), 1);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_conduct", 32'(conduct_comparison), 0);
    chk("rst_sample", 32'(sample_en), 0);
    chk("rst_mux_sel", 32'(mux_sel), 0);
    chk("rst_error", 32'(error), 0);
    tick();
    reset = 1'b1;
    #1;
    chk("rel_sar_clear_first", 32'(sar_clear), 1);
    tick();
    chk("rel_sar_clear_after", 32'(sar_clear), 0);
    repeat (5) tick();

    // Single-channel conversions from the vector table.
    for (int i = 0; i < 5; i++) begin
      quantized_voltage = tbl[i].qv;
      feedback_value    = tbl[i].fb;
      pulse(tbl[i].req);
      chk("vec_arb_busy", 32'(busy), 1);
      wait_valid(n);
      chk("vec_latency", 32'(n + 1), LAT);
      chk("vec_data", 32'(result_data), 32'(tbl[i].data));
      chk("vec_channel", 32'(result_channel), 32'(tbl[i].ch));
      chk("vec_mux_sel", 32'(mux_sel), 32'(tbl[i].ch));
      handshake();
      chk("vec_valid_drop", 32'(result_valid), 0);
      chk("vec_idle", 32'(busy), 0);
      tick();
    end

    // All four at once, consumer always ready: strict order, no extra bubble.
    do_reset();
    result_ready = 1'b1;
    quantized_voltage = 10'h100; feedback_value = 1'b1;
    pulse(4'b1111);
    for (int k = 0; k < 4; k++) begin
      wait_valid(n);
      chk("b2b_gap", 32'(n + 1), LAT);
      chk("b2b_channel", 32'(result_channel), 32'(k));
      chk("b2b_data", 32'(result_data), 32'h101);
      tick();
    end
    result_ready = 1'b0;

    // Backpressure: result held 50 cycles, ch2 stays pending behind it.
    do_reset();
    quantized_voltage = 10'h0F0; feedback_value = 1'b0;
    pulse(4'b0101);
    wait_valid(n);
    chk("bp_channel", 32'(result_channel), 0);
    quantized_voltage = 10'h3C0;
    ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (result_valid !== 1'b1 || result_data !== 10'h0F0 || result_channel !== 2'd0 ||
          sample_en !== 1'b0 || conduct_comparison !== 1'b0) ok = 1'b0;
    end
    chk("bp_hold_stable", 32'(ok), 1);
    handshake();
    chk("bp_arb_valid", 32'(result_valid), 0);
    chk("bp_arb_busy", 32'(busy), 1);
    chk("bp_arb_sample", 32'(sample_en), 0);
    tick();
    chk("bp_settle_sample", 32'(sample_en), 1);
    chk("bp_settle_mux", 32'(mux_sel), 2);
    wait_valid(n);
    chk("bp_next_latency", 32'(n + 1), LAT - 1);
    chk("bp_next_channel", 32'(result_channel), 2);
    chk("bp_next_data", 32'(result_data), 32'h3C0);
    handshake();

    // Repeated requests on an already-pending channel merge.
    do_reset();
    quantized_voltage = 10'h011; feedback_value = 1'b0;
    pulse(4'b0001);
    tick();
    pulse(4'b0010);
    tick();
    pulse(4'b0010);
    tick();
    pulse(4'b0010);
    wait_valid(n);
    chk("merge_first_ch", 32'(result_channel), 0);
    handshake();
    wait_valid(n);
    chk("merge_second_ch", 32'(result_channel), 1);
    handshake();
    extra = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (busy || result_valid) extra++;
    end
    chk("merge_no_extra", 32'(extra), 0);

    // Reset in the middle of CONVERT.
    pulse(4'b1000);
    repeat (10) tick();
    chk("rstc_pre_conduct", 32'(conduct_comparison), 1);
    reset = 1'b0;
    #1;
    chk("rstc_conduct", 32'(conduct_comparison), 0);
    chk("rstc_busy", 32'(busy), 0);
    chk("rstc_sample", 32'(sample_en), 0);
    chk("rstc_valid", 32'(result_valid), 0);
    chk("rstc_sar_clear", 32'(sar_clear), 1);
    chk("rstc_mux_sel", 32'(mux_sel), 0);
    chk("rstc_data", 32'(result_data), 0);
    tick();
    reset = 1'b1;
    #1;
    chk("rstc_rel_clear", 32'(sar_clear), 1);
    tick();
    chk("rstc_rel_clear_drop", 32'(sar_clear), 0);
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (busy || result_valid) extra++;
    end
    chk("rstc_no_stale", 32'(extra), 0);
    chk("error_default", 32'(error), 0);

`ifdef SAR_SCHED_WATCHDOG_EN
    // eoc withheld: abort in CONVERT cycle 22, then serve channel 1.
    do_reset();
    eoc_en = 1'b0;
    quantized_voltage = 10'h2A4; feedback_value = 1'b1;
    pulse(4'b0011);
    repeat (25) tick();
    chk("wd_pre_error", 32'(error), 0);
    chk("wd_pre_conduct", 32'(conduct_comparison), 1);
    tick();
    chk("wd_error", 32'(error), 1);
    chk("wd_sar_clear", 32'(sar_clear), 1);
    chk("wd_conduct_drop", 32'(conduct_comparison), 0);
    chk("wd_no_valid", 32'(result_valid), 0);
    eoc_en = 1'b1;
    tick();
    chk("wd_clear_drop", 32'(sar_clear), 0);
    chk("wd_arb_busy", 32'(busy), 1);
    wait_valid(n);
    chk("wd_next_latency", 32'(n), LAT - 1);
    chk("wd_next_channel", 32'(result_channel), 1);
    chk("wd_next_data", 32'(result_data), 32'h2A5);
    chk("wd_error_sticky", 32'(error), 1);
    handshake();
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
